// File: rtl/proc_pkg.sv
// Shared types and constants for the processor issue sequencer.
// Opcode encoding matches the downstream processor's op bus.
package proc_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 5;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_WR     = 3'b000;
    localparam logic [OP_W-1:0] OP_RD1    = 3'b001;
    localparam logic [OP_W-1:0] OP_RD2    = 3'b010;
    localparam logic [OP_W-1:0] OP_WR_RD1 = 3'b011;
    localparam logic [OP_W-1:0] OP_WR_RD2 = 3'b100;
    localparam logic [OP_W-1:0] OP_ADD    = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB    = 3'b110;
    localparam logic [OP_W-1:0] OP_SHL    = 3'b111;

    // One buffered instruction: 3 + 3*5 + 16 = 34 bits.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] read1;
        logic [REG_AW-1:0] read2;
        logic [REG_AW-1:0] write;
        logic [DATA_W-1:0] wdata;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } issue_state_e;

endpackage

// File: rtl/proc_instr_fifo.sv
// Synchronous instruction FIFO, power-of-two depth. Pointers carry one
// extra wrap bit so equal indices can be told apart as full or empty.
module proc_instr_fifo
    import proc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  instr_t din_i,
    input  logic   pop_i,
    output instr_t dout_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("proc_instr_fifo: DEPTH must be a power of two >= 2");
    end

    instr_t      mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments only.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; clearing the pointers is enough to empty it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/proc_issue_seq.sv
// Issue sequencer: buffers instructions and drives the processor bus one
// instruction at a time. Optional WAIT abort enabled by PROC_ISSUE_TIMEOUT_EN.
module proc_issue_seq
    import proc_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_read1,
    input  logic [REG_AW-1:0] in_read2,
    input  logic [REG_AW-1:0] in_write,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              p_input_valid,
    output logic [OP_W-1:0]   p_op,
    output logic [REG_AW-1:0] p_read1,
    output logic [REG_AW-1:0] p_read2,
    output logic [REG_AW-1:0] p_write,
    output logic [DATA_W-1:0] p_wdata,
    input  logic              p_done,
    input  logic [DATA_W-1:0] p_rd1,
    input  logic [DATA_W-1:0] p_rd2,
    input  logic [DATA_W-1:0] p_arith,
    output logic              res_valid,
    output logic [OP_W-1:0]   res_op,
    output logic [DATA_W-1:0] res_rd1,
    output logic [DATA_W-1:0] res_rd2,
    output logic [DATA_W-1:0] res_arith,
    output logic              busy,
    output logic              err_timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("proc_issue_seq: TIMEOUT_CYCLES must be >= 1");
    end

    issue_state_e      state_q;
    instr_t            issue_q;
    logic              p_valid_q;
    logic              res_valid_q;
    logic [OP_W-1:0]   res_op_q;
    logic [DATA_W-1:0] res_rd1_q;
    logic [DATA_W-1:0] res_rd2_q;
    logic [DATA_W-1:0] res_arith_q;

    instr_t push_instr;
    instr_t head_instr;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;

    assign push_instr = '{op: in_op, read1: in_read1, read2: in_read2,
                          write: in_write, wdata: in_wdata};
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

    proc_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .din_i   (push_instr),
        .pop_i   (fifo_pop),
        .dout_o  (head_instr),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef PROC_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issue_q     <= '0;
            p_valid_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_op_q    <= '0;
            res_rd1_q   <= '0;
            res_rd2_q   <= '0;
            res_arith_q <= '0;
`ifdef PROC_ISSUE_TIMEOUT_EN
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            res_valid_q <= 1'b0;
`ifdef PROC_ISSUE_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        issue_q   <= head_instr;
                        p_valid_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                // done may still be high from the previous instruction here.
                ST_ISSUE: begin
`ifdef PROC_ISSUE_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (p_done) begin
                        res_op_q    <= issue_q.op;
                        res_rd1_q   <= p_rd1;
                        res_rd2_q   <= p_rd2;
                        res_arith_q <= p_arith;
                        res_valid_q <= 1'b1;
                        p_valid_q   <= 1'b0;
                        state_q     <= ST_GAP;
                    end
`ifdef PROC_ISSUE_TIMEOUT_EN
                    else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q     <= 1'b1;
                        p_valid_q <= 1'b0;
                        state_q   <= ST_GAP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PROC_ISSUE_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign in_ready      = !fifo_full;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
    assign p_input_valid = p_valid_q;
    assign p_op          = issue_q.op;
    assign p_read1       = issue_q.read1;
    assign p_read2       = issue_q.read2;
    assign p_write       = issue_q.write;
    assign p_wdata       = issue_q.wdata;
    assign res_valid     = res_valid_q;
    assign res_op        = res_op_q;
    assign res_rd1       = res_rd1_q;
    assign res_rd2       = res_rd2_q;
    assign res_arith     = res_arith_q;

endmodule

// File: tb/tb_proc_issue_seq.sv
// Directed bench for proc_issue_seq with a small behavioural processor
// (register file + ALU, 1-cycle register ops, 20-cycle ALU ops).
module tb_proc_issue_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_read1, in_read2, in_write;
    logic [15:0] in_wdata;
    logic        p_input_valid;
    logic [2:0]  p_op;
    logic [4:0]  p_read1, p_read2, p_write;
    logic [15:0] p_wdata;
    logic        p_done;
    logic [15:0] p_rd1, p_rd2, p_arith;
    logic        res_valid;
    logic [2:0]  res_op;
    logic [15:0] res_rd1, res_rd2, res_arith;
    logic        busy;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    proc_issue_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_read1      (in_read1),
        .in_read2      (in_read2),
        .in_write      (in_write),
        .in_wdata      (in_wdata),
        .p_input_valid (p_input_valid),
        .p_op          (p_op),
        .p_read1       (p_read1),
        .p_read2       (p_read2),
        .p_write       (p_write),
        .p_wdata       (p_wdata),
        .p_done        (p_done),
        .p_rd1         (p_rd1),
        .p_rd2         (p_rd2),
        .p_arith       (p_arith),
        .res_valid     (res_valid),
        .res_op        (res_op),
        .res_rd1       (res_rd1),
        .res_rd2       (res_rd2),
        .res_arith     (res_arith),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural processor model
    logic [15:0] rf [32];
    logic        m_busy, m_hold, m_stall;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_hold  <= 1'b0;
            m_cnt   <= 0;
            p_done  <= 1'b0;
            p_rd1   <= '0;
            p_rd2   <= '0;
            p_arith <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (!p_input_valid) begin
            m_busy <= 1'b0;
            m_hold <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (!m_stall) begin
                m_busy <= 1'b0;
                m_hold <= 1'b1;
                p_done <= 1'b1;
                case (p_op)
                    3'b000: rf[p_write] <= p_wdata;
                    3'b001: p_rd1 <= rf[p_read1];
                    3'b010: begin p_rd1 <= rf[p_read1]; p_rd2 <= rf[p_read2]; end
                    3'b011: begin rf[p_write] <= p_wdata; p_rd1 <= rf[p_read1]; end
                    3'b100: begin
                        rf[p_write] <= p_wdata;
                        p_rd1 <= rf[p_read1];
                        p_rd2 <= rf[p_read2];
                    end
                    3'b101: begin
                        p_arith <= rf[p_read1] + rf[p_read2];
                        rf[p_write] <= rf[p_read1] + rf[p_read2];
                        p_rd1 <= rf[p_read1];
                        p_rd2 <= rf[p_read2];
                    end
                    3'b110: begin
                        p_arith <= rf[p_read1] - rf[p_read2];
                        rf[p_write] <= rf[p_read1] - rf[p_read2];
                        p_rd1 <= rf[p_read1];
                        p_rd2 <= rf[p_read2];
                    end
                    default: begin
                        p_arith <= rf[p_read1] << 1;
                        rf[p_write] <= rf[p_read1] << 1;
                        p_rd1 <= rf[p_read1];
                    end
                endcase
            end
        end else if (!m_hold) begin
            m_busy <= 1'b1;
            p_done <= 1'b0;
            m_cnt  <= (p_op >= 3'b101) ? 20 : 1;
        end
    end

    // Result / error monitor
    typedef struct {
        logic [2:0]  op;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] arith;
    } res_t;

    res_t res_q[$];
    int   err_pulses = 0;

    always @(negedge clk) begin
        if (rst_n && res_valid) res_q.push_back('{res_op, res_rd1, res_rd2, res_arith});
        if (rst_n && err_timeout) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] w, input logic [15:0] wd);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_read1 = r1;
        in_read2 = r2;
        in_write = w;
        in_wdata = wd;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (res_q.size() < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (res_q.size() < n) check("wait_results", 32'(res_q.size()), 32'(n));
    endtask

    task automatic wait_issue();
        int k = 0;
        while (!p_input_valid && k < 300) begin
            @(posedge clk);
            #1 k++;
        end
        if (!p_input_valid) check("wait_issue", 32'(p_input_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p_iv"},      32'(p_input_valid), 32'd0);
        check({tag, "_p_op"},      32'(p_op),          32'd0);
        check({tag, "_p_read1"},   32'(p_read1),       32'd0);
        check({tag, "_p_read2"},   32'(p_read2),       32'd0);
        check({tag, "_p_write"},   32'(p_write),       32'd0);
        check({tag, "_p_wdata"},   32'(p_wdata),       32'd0);
        check({tag, "_res_valid"}, 32'(res_valid),     32'd0);
        check({tag, "_res_op"},    32'(res_op),        32'd0);
        check({tag, "_res_rd1"},   32'(res_rd1),       32'd0);
        check({tag, "_res_rd2"},   32'(res_rd2),       32'd0);
        check({tag, "_res_arith"}, 32'(res_arith),     32'd0);
        check({tag, "_err"},       32'(err_timeout),   32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_in_ready"},  32'(in_ready),      32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_read1 = '0;
        in_read2 = '0;
        in_write = '0;
        in_wdata = '0;
        m_stall  = 1'b0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Issue and result latency for a register write r3 = 00A5
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'b000;
        in_write = 5'd3;
        in_wdata = 16'h00A5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("lat_iv_n1", 32'(p_input_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_iv_n2", 32'(p_input_valid), 32'd1);
        check("lat_p_write", 32'(p_write), 32'd3);
        check("lat_p_wdata", 32'(p_wdata), 32'h00A5);
        @(posedge clk);
        #1 check("lat_res_c1", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1 check("lat_res_c2", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_res_c3", 32'(res_valid), 32'd1);
        check("lat_iv_drop", 32'(p_input_valid), 32'd0);

        push(3'b001, 5'd3, 5'd0, 5'd0, 16'h0);
        wait_results(2);
        check("rd_r3_op",  32'(res_q[1].op),  32'd1);
        check("rd_r3_rd1", 32'(res_q[1].rd1), 32'h00A5);

        // r1=7, r2=5, r4=r1+r2, read r4
        push(3'b000, 5'd0, 5'd0, 5'd1, 16'd7);
        push(3'b000, 5'd0, 5'd0, 5'd2, 16'd5);
        push(3'b101, 5'd1, 5'd2, 5'd4, 16'h0);
        push(3'b001, 5'd4, 5'd0, 5'd0, 16'h0);
        wait_results(6);
        check("add_op",    32'(res_q[4].op),    32'd5);
        check("add_arith", 32'(res_q[4].arith), 32'd12);
        check("rd_r4_rd1", 32'(res_q[5].rd1),   32'd12);

        // r1=5, r2=7, subtract wraps
        push(3'b000, 5'd0, 5'd0, 5'd1, 16'd5);
        push(3'b000, 5'd0, 5'd0, 5'd2, 16'd7);
        push(3'b110, 5'd1, 5'd2, 5'd6, 16'h0);
        wait_results(9);
        check("sub_op",    32'(res_q[8].op),    32'd6);
        check("sub_arith", 32'(res_q[8].arith), 32'hFFFE);

        // FIFO fill while an ALU op stalls the issue path
        push(3'b101, 5'd1, 5'd2, 5'd7, 16'h0);
        wait_issue();
        check("fill_ready_empty", 32'(in_ready), 32'd1);
        push(3'b000, 5'd0, 5'd0, 5'd8, 16'h1111);
        push(3'b001, 5'd8, 5'd0, 5'd0, 16'h0);
        push(3'b000, 5'd0, 5'd0, 5'd9, 16'h2222);
        push(3'b010, 5'd8, 5'd9, 5'd0, 16'h0);
        check("fill_ready_full", 32'(in_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        push(3'b001, 5'd7, 5'd0, 5'd0, 16'h0);
        wait_results(15);
        check("fill_op0", 32'(res_q[9].op),  32'd5);
        check("fill_op1", 32'(res_q[10].op), 32'd0);
        check("fill_op2", 32'(res_q[11].op), 32'd1);
        check("fill_op3", 32'(res_q[12].op), 32'd0);
        check("fill_op4", 32'(res_q[13].op), 32'd2);
        check("fill_op5", 32'(res_q[14].op), 32'd1);
        check("fill_add_arith", 32'(res_q[9].arith), 32'd12);
        check("fill_rd_r8",  32'(res_q[11].rd1), 32'h1111);
        check("fill_rd2_r8", 32'(res_q[13].rd1), 32'h1111);
        check("fill_rd2_r9", 32'(res_q[13].rd2), 32'h2222);
        check("fill_rd_r7",  32'(res_q[14].rd1), 32'h000C);
        repeat (4) @(posedge clk);
        #1 check("idle_busy", 32'(busy), 32'd0);

        // Processor never completes
        m_stall = 1'b1;
        push(3'b001, 5'd8, 5'd0, 5'd0, 16'h0);
        wait_issue();
`ifdef PROC_ISSUE_TIMEOUT_EN
        begin
            int k = 0;
            while (!err_timeout && k < 200) begin
                @(posedge clk);
                #1 k++;
            end
            m_stall = 1'b0;
            check("to_cycle", 32'(k), 32'd65);
            check("to_iv_drop", 32'(p_input_valid), 32'd0);
            @(posedge clk);
            #1 check("to_pulse_end", 32'(err_timeout), 32'd0);
            check("to_no_result", 32'(res_q.size()), 32'd15);
            check("to_pulses", 32'(err_pulses), 32'd1);
            push(3'b001, 5'd7, 5'd0, 5'd0, 16'h0);
            wait_results(16);
            check("to_next_op",  32'(res_q[15].op),  32'd1);
            check("to_next_rd1", 32'(res_q[15].rd1), 32'h000C);
        end
`else
        repeat (100) @(posedge clk);
        #1;
        check("hold_err", 32'(err_pulses), 32'd0);
        check("hold_iv", 32'(p_input_valid), 32'd1);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_no_result", 32'(res_q.size()), 32'd15);
        @(negedge clk);
        rst_n   = 1'b0;
        m_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Asynchronous reset in the middle of an ALU WAIT
        push(3'b000, 5'd0, 5'd0, 5'd1, 16'd3);
        push(3'b101, 5'd1, 5'd1, 5'd10, 16'h0);
        push(3'b001, 5'd1, 5'd0, 5'd0, 16'h0);
        begin
            int k = 0;
            while (!(p_input_valid && p_op == 3'b101) && k < 300) begin
                @(posedge clk);
                #1 k++;
            end
        end
        repeat (5) @(posedge clk);
        #2;
        check("mid_wait_iv", 32'(p_input_valid), 32'd1);
        check("mid_wait_op", 32'(p_op), 32'd5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_iv", 32'(p_input_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_issue_seq.md
# proc_issue_seq

Instruction issue sequencer directly upstream of `processor`. It buffers register-file/ALU instructions in a small FIFO and issues them one at a time on `processor`'s `input_valid`/`op`/`read1`/`read2`/`write`/`write_data` bus. For each instruction it holds the bus stable until `done`, then captures the read/ALU results into a result port. This removes the need for the testbench or controller to handle `processor`'s variable latency (1 cycle for register ops, about 20 cycles for ALU ops).

## Interface
- `FIFO_DEPTH`, 4, instruction buffer entries (power of two, ≥2)
- `TIMEOUT_CYCLES`, 64, maximum WAIT cycles before abort (used only with the timeout feature)
- `clk` in 1: single clock, rising-edge logic
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: instruction push request
- `in_ready` out 1: FIFO not full
- `in_op` in 3: opcode 000–111 (`processor` encoding)
- `in_read1`, `in_read2`, `in_write` in 5 each: register indices
- `in_wdata` in 16: write data (ops 000/011/100)
- `p_input_valid` out 1: to `processor.input_valid`
- `p_op` out 3, `p_read1`/`p_read2`/`p_write` out 5, `p_wdata` out 16: to `processor`
- `p_done` in 1: from `processor.done`
- `p_rd1`, `p_rd2`, `p_arith` in 16: from `processor` `read_data_1`/`read_data_2`/`arith_out`
- `res_valid` out 1: one-cycle pulse, result captured
- `res_op` out 3, `res_rd1`/`res_rd2`/`res_arith` out 16: captured results
- `busy` out 1: FSM not IDLE or FIFO non-empty
- `err_timeout` out 1: one-cycle pulse on abort

## Operation
- Push: accepted when `in_valid && in_ready`. Instruction fields are stored as one 34-bit entry.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the issue registers, set `p_input_valid`=1, go to ISSUE.
  - ISSUE: hold for exactly 1 cycle, then go to WAIT. `p_done` is ignored here because it may be stale from the previous instruction; `processor` clears it on this edge.
  - WAIT: hold `p_*` stable and `p_input_valid`=1. When `p_done`=1 is sampled: capture `p_rd1`/`p_rd2`/`p_arith` and `p_op` into `res_*`, pulse `res_valid`, drive `p_input_valid`=0, go to GAP.
  - GAP: `p_input_valid`=0 for 1 cycle so `processor` sees a deasserted strobe, then go to IDLE.
- Capture is unconditional. Fields that are meaningless for the op keep whatever `processor` drives: op 000 has no reads, ops 001/011/111 have no `rd2`, ops 000–100 have no arith.
- `res_*` data holds until the next capture. `res_valid` has no backpressure.
- Simultaneous push and pop with the FIFO full: the pop frees a slot, but `in_ready` is registered from the pre-pop count, so the push is refused that cycle.
- Reset (asynchronous, any state, including mid-WAIT):
  - FSM goes to IDLE, FIFO is emptied.
  - All outputs go to 0: `p_input_valid`, `p_*`, `res_*`, `res_valid`, `err_timeout`, `busy`.
  - `in_ready` is 1 after reset.

## Timing
- Issue latency: push in cycle N with FSM IDLE and FIFO empty → `p_input_valid` high from cycle N+2 (one cycle for the FIFO write, one for the pop).
- Register ops (000–100): `done` is visible at the WAIT posedge following ISSUE. `res_valid` is asserted 3 cycles after `p_input_valid` rises.
- ALU ops (101–111): WAIT lasts until `processor` completes, about 20 cycles.
- Back-to-back instructions: minimum 4-cycle issue interval (ISSUE, WAIT≥1, GAP, IDLE).
- `p_input_valid` is high at the edge where `done` is sampled. `processor` re-executes the same instruction once on that edge; this is tolerated because register writes and reads are idempotent.

## Configuration
- `PROC_ISSUE_TIMEOUT_EN`, compiled in:
  - A WAIT-cycle counter, reset on entry to WAIT.
  - When it reaches `TIMEOUT_CYCLES`: pulse `err_timeout`, drop `p_input_valid`, go to GAP, no `res_valid`.
  - The next instruction proceeds normally.
- Compiled out: no counter. WAIT holds indefinitely and `err_timeout` is tied to 0.

## Structure
- Shared package `proc_pkg`:
  - opcode constants `OP_WR`=000 … `OP_SHL`=111
  - `DATA_W`=16, `REG_AW`=5, `OP_W`=3
  - packed instruction struct (34 bits)
  - FSM state enum
- Sub-module `proc_instr_fifo`: parameterised depth, synchronous, with full/empty flags. Pointers carry an extra wrap bit for the full/empty distinction.

## Test plan
- Reset mid-WAIT of op 101: assert `rst_n`=0 → all outputs 0 immediately, FIFO empty, `in_ready`=1.
- Push op 000 (write r3=16'h00A5), then op 001 (read1=r3) → second `res_valid` with `res_rd1`=16'h00A5, `res_op`=001.
- Write r1=7 and r2=5, then op 101 (r1+r2 → write r4), then op 001 r4 → `res_arith`=12 on the 101 result, later `res_rd1`=12.
- Op 110 with r1=5, r2=7 → `res_arith`=16'hFFFE (wrap).
- Push 5 instructions with `FIFO_DEPTH`=4 while the FSM is stalled on an ALU op → `in_ready` drops after 4 are stored; all 5 eventually execute in order.
- With `PROC_ISSUE_TIMEOUT_EN` and `p_done` forced 0 → `err_timeout` pulses at WAIT cycle 64, no `res_valid`, next instruction issues.
